// File: rtl/frame_tx_scheduler.sv
// Burst scheduler for the 64-bit frame generator: start pulses, inter-frame gaps and STOP_DATA selection.
// Watches the generator's output for SOF/EOF, counts frames and flags a stalled generator.
module frame_tx_scheduler #(
  parameter int         DATA_WIDTH     = 64,
  parameter int         CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter logic [7:0] START_CODE     = 8'hFB,
  parameter logic [7:0] TERMINATE_CODE = 8'hFD,
  parameter logic [7:0] STOP_DATA      = 8'h02,
  parameter int         SOF_TIMEOUT    = 8,
  parameter int         EOF_TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_go,
  input  logic                  i_abort,
  input  logic [15:0]           i_frame_count,
  input  logic [7:0]            i_gap_cycles,
  input  logic [7:0]            i_stop_period,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
  output logic                  o_start,
  output logic [7:0]            o_interrupt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [15:0]           o_frames_sent,
  output logic                  o_timeout
);

  localparam int WD_MAX = (EOF_TIMEOUT > SOF_TIMEOUT) ? EOF_TIMEOUT : SOF_TIMEOUT;
  localparam int WD_W   = $clog2(WD_MAX);
  localparam logic [WD_W-1:0] SOF_LAST = WD_W'(SOF_TIMEOUT - 1);
  localparam logic [WD_W-1:0] EOF_LAST = WD_W'(EOF_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_SOF, WAIT_EOF, GAP, DONE} state_t;

  state_t          state, state_nxt;
  logic [15:0]     target, target_nxt;
  logic [7:0]      gap, gap_nxt;
  logic [7:0]      period, period_nxt;
  logic [7:0]      stop_cnt, stop_cnt_nxt;
  logic [7:0]      gap_cnt, gap_cnt_nxt;
  logic [WD_W-1:0] wd, wd_nxt;
  logic [15:0]     frames_nxt;
  logic [7:0]      intr_nxt;
  logic            timeout_nxt;
  logic [7:0]      arm_period, arm_cnt, arm_eff, arm_cnt_nxt, arm_intr;
  logic            arm_hit;
  logic            sof, eof;

  assign sof = (i_tx_ctrl == CTRL_WIDTH'(1)) && (i_tx_data[DATA_WIDTH-1 -: 8] == START_CODE);
  assign eof = (i_tx_ctrl == CTRL_WIDTH'(1)) && (i_tx_data[DATA_WIDTH-1 -: 8] == TERMINATE_CODE);

  always_comb begin
    state_nxt    = state;
    target_nxt   = target;
    gap_nxt      = gap;
    period_nxt   = period;
    stop_cnt_nxt = stop_cnt;
    gap_cnt_nxt  = gap_cnt;
    wd_nxt       = wd;
    frames_nxt   = o_frames_sent;
    intr_nxt     = o_interrupt;
    timeout_nxt  = o_timeout;

    // Stop-period down-counter: 0 means "reload", the frame that sees 1 carries STOP_DATA.
    if (state == IDLE) begin
      arm_period = i_stop_period;
      arm_cnt    = 8'd0;
    end else begin
      arm_period = period;
      arm_cnt    = stop_cnt;
    end
    arm_eff  = (arm_cnt == 8'd0) ? arm_period : arm_cnt;
    arm_hit  = (arm_period != 8'd0) && (arm_eff == 8'd1);
    arm_intr = arm_hit ? STOP_DATA : 8'd0;
    if (arm_period == 8'd0)
      arm_cnt_nxt = 8'd0;
    else if (arm_hit)
      arm_cnt_nxt = arm_period;
    else
      arm_cnt_nxt = arm_eff - 8'd1;

    if (state != IDLE && i_abort) begin
      state_nxt = IDLE;
      intr_nxt  = 8'd0;
    end else begin
      case (state)
        IDLE: if (i_go) begin
          target_nxt   = i_frame_count;
          gap_nxt      = i_gap_cycles;
          period_nxt   = i_stop_period;
          frames_nxt   = 16'd0;
          timeout_nxt  = 1'b0;
          state_nxt    = ARM;
          intr_nxt     = arm_intr;
          stop_cnt_nxt = arm_cnt_nxt;
          wd_nxt       = '0;
        end
        ARM: begin
          state_nxt = WAIT_SOF;
          wd_nxt    = '0;
        end
        WAIT_SOF: begin
          if (sof) begin
            state_nxt = WAIT_EOF;
            wd_nxt    = '0;
          end else if (wd == SOF_LAST) begin
            state_nxt   = IDLE;
            timeout_nxt = 1'b1;
            intr_nxt    = 8'd0;
          end else begin
            wd_nxt = wd + 1'b1;
          end
        end
        WAIT_EOF: begin
          if (eof) begin
            frames_nxt = o_frames_sent + 16'd1;
            intr_nxt   = 8'd0;
            if (target != 16'd0 && frames_nxt == target) begin
              state_nxt = DONE;
            end else if (gap == 8'd0) begin
              state_nxt    = ARM;
              intr_nxt     = arm_intr;
              stop_cnt_nxt = arm_cnt_nxt;
              wd_nxt       = '0;
            end else begin
              state_nxt   = GAP;
              gap_cnt_nxt = 8'd0;
            end
          end else if (wd == EOF_LAST) begin
            state_nxt   = IDLE;
            timeout_nxt = 1'b1;
            intr_nxt    = 8'd0;
          end else begin
            wd_nxt = wd + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == gap - 8'd1) begin
            state_nxt    = ARM;
            intr_nxt     = arm_intr;
            stop_cnt_nxt = arm_cnt_nxt;
            wd_nxt       = '0;
          end else begin
            gap_cnt_nxt = gap_cnt + 8'd1;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Pulse outputs are derived from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      target        <= 16'd0;
      gap           <= 8'd0;
      period        <= 8'd0;
      stop_cnt      <= 8'd0;
      gap_cnt       <= 8'd0;
      wd            <= '0;
      o_frames_sent <= 16'd0;
      o_interrupt   <= 8'd0;
      o_timeout     <= 1'b0;
      o_start       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      state         <= state_nxt;
      target        <= target_nxt;
      gap           <= gap_nxt;
      period        <= period_nxt;
      stop_cnt      <= stop_cnt_nxt;
      gap_cnt       <= gap_cnt_nxt;
      wd            <= wd_nxt;
      o_frames_sent <= frames_nxt;
      o_interrupt   <= intr_nxt;
      o_timeout     <= timeout_nxt;
      o_start       <= (state_nxt == ARM);
      o_busy        <= (state_nxt != IDLE);
      o_done        <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Directed bench for frame_tx_scheduler; the bench plays the frame generator by driving SOF/EOF words.
module tb_frame_tx_scheduler;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_go = 1'b0;
  logic        i_abort = 1'b0;
  logic [15:0] i_frame_count = 16'd0;
  logic [7:0]  i_gap_cycles = 8'd0;
  logic [7:0]  i_stop_period = 8'd0;
  logic [63:0] i_tx_data = 64'h0707070707070707;
  logic [7:0]  i_tx_ctrl = 8'h00;
  logic        o_start;
  logic [7:0]  o_interrupt;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_frames_sent;
  logic        o_timeout;

  int checks = 0;
  int errors = 0;

  frame_tx_scheduler dut (
    .clk(clk), .i_rst(i_rst), .i_go(i_go), .i_abort(i_abort),
    .i_frame_count(i_frame_count), .i_gap_cycles(i_gap_cycles), .i_stop_period(i_stop_period),
    .i_tx_data(i_tx_data), .i_tx_ctrl(i_tx_ctrl),
    .o_start(o_start), .o_interrupt(o_interrupt), .o_busy(o_busy), .o_done(o_done),
    .o_frames_sent(o_frames_sent), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic driveIdle();
    i_tx_ctrl = 8'h00;
    i_tx_data = 64'h0707070707070707;
  endtask

  task automatic driveSof();
    i_tx_ctrl = 8'h01;
    i_tx_data = {8'hFB, 56'h55555555555555};
  endtask

  task automatic driveEof();
    i_tx_ctrl = 8'h01;
    i_tx_data = {8'hFD, 56'h07070707070707};
  endtask

  // Pulse i_go with a config; returns at the negedge where the scheduler should sit in ARM.
  task automatic applyStimulus(input logic [15:0] cnt, input logic [7:0] gap, input logic [7:0] per);
    i_frame_count = cnt;
    i_gap_cycles  = gap;
    i_stop_period = per;
    i_go          = 1'b1;
    @(negedge clk);
    i_go = 1'b0;
  endtask

  // Entered with the scheduler in ARM; leaves one cycle after EOF was presented.
  task automatic runFrame(input int body, input logic [7:0] exp_intr);
    checkOutput("arm_start", o_start, 1);
    checkOutput("arm_intr", o_interrupt, exp_intr);
    @(negedge clk);
    driveSof();
    @(negedge clk);
    driveIdle();
    checkOutput("frame_start_low", o_start, 0);
    checkOutput("frame_intr_held", o_interrupt, exp_intr);
    repeat (body) @(negedge clk);
    driveEof();
    @(negedge clk);
    driveIdle();
  endtask

  initial begin
    @(negedge clk);
    checkOutput("rst_start", o_start, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_intr", o_interrupt, 0);
    checkOutput("rst_frames", o_frames_sent, 0);
    checkOutput("rst_timeout", o_timeout, 0);
    i_rst = 1'b0;
    @(negedge clk);

    $display("[TB] three frames, gap 4, no stop code");
    applyStimulus(16'd3, 8'd4, 8'd0);
    checkOutput("t1_busy", o_busy, 1);
    for (int f = 1; f <= 3; f++) begin
      runFrame(3, 8'h00);
      checkOutput("t1_frames", o_frames_sent, 16'(f));
      checkOutput("t1_intr_after_eof", o_interrupt, 0);
      if (f < 3) begin
        repeat (4) begin
          checkOutput("t1_gap_start", o_start, 0);
          @(negedge clk);
        end
      end
    end
    checkOutput("t1_done", o_done, 1);
    checkOutput("t1_done_busy", o_busy, 1);
    @(negedge clk);
    checkOutput("t1_done_pulse", o_done, 0);
    checkOutput("t1_idle_busy", o_busy, 0);
    checkOutput("t1_final_frames", o_frames_sent, 3);

    $display("[TB] four frames, gap 0, stop every 2nd");
    applyStimulus(16'd4, 8'd0, 8'd2);
    for (int f = 1; f <= 4; f++) begin
      runFrame(2, (f % 2 == 0) ? 8'h02 : 8'h00);
      checkOutput("t2_frames", o_frames_sent, 16'(f));
    end
    checkOutput("t2_done", o_done, 1);
    checkOutput("t2_intr_done", o_interrupt, 0);
    @(negedge clk);
    checkOutput("t2_idle_busy", o_busy, 0);

    $display("[TB] SOF never arrives");
    applyStimulus(16'd1, 8'd0, 8'd0);
    checkOutput("t3_start", o_start, 1);
    repeat (8) @(negedge clk);
    checkOutput("t3_timeout_early", o_timeout, 0);
    checkOutput("t3_busy_waiting", o_busy, 1);
    @(negedge clk);
    checkOutput("t3_timeout", o_timeout, 1);
    checkOutput("t3_busy", o_busy, 0);
    checkOutput("t3_done", o_done, 0);
    repeat (3) @(negedge clk);
    checkOutput("t3_timeout_sticky", o_timeout, 1);
    applyStimulus(16'd1, 8'd0, 8'd0);
    checkOutput("t3_timeout_cleared", o_timeout, 0);
    runFrame(1, 8'h00);
    checkOutput("t3_rerun_done", o_done, 1);
    checkOutput("t3_rerun_frames", o_frames_sent, 1);
    @(negedge clk);

    $display("[TB] continuous run, abort with go during frame 2");
    applyStimulus(16'd0, 8'd0, 8'd1);
    runFrame(1, 8'h02);
    checkOutput("t4_frames1", o_frames_sent, 1);
    checkOutput("t4_arm2_start", o_start, 1);
    checkOutput("t4_arm2_intr", o_interrupt, 8'h02);
    @(negedge clk);
    driveSof();
    @(negedge clk);
    driveEof();
    i_abort = 1'b1;
    i_go    = 1'b1;
    @(negedge clk);
    driveIdle();
    i_abort = 1'b0;
    i_go    = 1'b0;
    checkOutput("t4_busy", o_busy, 0);
    checkOutput("t4_intr", o_interrupt, 0);
    checkOutput("t4_frames", o_frames_sent, 1);
    checkOutput("t4_start", o_start, 0);
    checkOutput("t4_done", o_done, 0);
    @(negedge clk);
    checkOutput("t4_still_idle", o_busy, 0);

    $display("[TB] go while busy, then reset mid-frame");
    applyStimulus(16'd2, 8'd1, 8'd0);
    runFrame(1, 8'h00);
    i_frame_count = 16'd5;
    i_gap_cycles  = 8'd3;
    i_stop_period = 8'd1;
    i_go          = 1'b1;
    checkOutput("t5_gap_start", o_start, 0);
    @(negedge clk);
    i_go = 1'b0;
    runFrame(1, 8'h00);
    checkOutput("t5_done", o_done, 1);
    checkOutput("t5_frames", o_frames_sent, 2);
    @(negedge clk);
    applyStimulus(16'd3, 8'd0, 8'd1);
    checkOutput("t5_arm_intr", o_interrupt, 8'h02);
    @(negedge clk);
    driveSof();
    @(negedge clk);
    driveIdle();
    #2 i_rst = 1'b1;
    #1;
    checkOutput("t5_rst_busy", o_busy, 0);
    checkOutput("t5_rst_intr", o_interrupt, 0);
    checkOutput("t5_rst_start", o_start, 0);
    checkOutput("t5_rst_done", o_done, 0);
    checkOutput("t5_rst_frames", o_frames_sent, 0);
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    applyStimulus(16'd1, 8'd0, 8'd0);
    runFrame(1, 8'h00);
    checkOutput("t5_restart_done", o_done, 1);
    checkOutput("t5_restart_frames", o_frames_sent, 1);
    @(negedge clk);
    checkOutput("t5_restart_idle", o_busy, 0);

    $display("[TB] EOF withheld");
    applyStimulus(16'd2, 8'd0, 8'd1);
    checkOutput("t6_arm_intr", o_interrupt, 8'h02);
    @(negedge clk);
    driveSof();
    @(negedge clk);
    driveIdle();
    repeat (63) @(negedge clk);
    checkOutput("t6_timeout_early", o_timeout, 0);
    checkOutput("t6_intr_held", o_interrupt, 8'h02);
    checkOutput("t6_busy_waiting", o_busy, 1);
    @(negedge clk);
    checkOutput("t6_timeout", o_timeout, 1);
    checkOutput("t6_intr", o_interrupt, 0);
    checkOutput("t6_busy", o_busy, 0);
    checkOutput("t6_frames", o_frames_sent, 0);
    checkOutput("t6_done", o_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
